// File: rtl/axi_crossbar_addr_adm_pkg.sv
// Shared types and elaboration helpers for the crossbar slave-port address admission stage.
package axi_crossbar_addr_adm_pkg;

    typedef struct packed {
        logic a;
        logic wc;
        logic rc;
    } out_valid_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_crossbar_addr_adm_tracker.sv
// Per-ID thread tracker: keeps transactions of one ID on a single destination and counts them.
module axi_crossbar_addr_adm_tracker
    import axi_crossbar_addr_adm_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IdW   = 8,
    parameter int unsigned DestW = 3,
    parameter int unsigned CntW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IdW-1:0]   req_id_i,
    input  logic [DestW-1:0] req_dest_i,
    input  logic             start_i,
    input  logic [IdW-1:0]   cpl_id_i,
    input  logic             cpl_valid_i,
    output logic             admit_o,
    output logic             cpl_hit_o
);

    logic [IdW-1:0]   id_q     [N];
    logic [DestW-1:0] dest_q   [N];
    logic [CntW-1:0]  cnt_q    [N];
    logic [CntW-1:0]  cnt_d    [N];
    logic [CntW-1:0]  cnt_post [N];
    logic [N-1:0]     cpl_hit, act_post, id_hit, dest_ok, sel_oh;
    logic             free_found;

    // Admission sees counts after this cycle's completion, so a draining thread is reusable.
    always_comb begin
        cpl_hit    = '0;
        act_post   = '0;
        id_hit     = '0;
        dest_ok    = '0;
        sel_oh     = '0;
        free_found = 1'b0;
        cnt_post   = '{default: '0};
        cnt_d      = '{default: '0};
        for (int t = 0; t < N; t++) begin
            cpl_hit[t]  = cpl_valid_i && (cnt_q[t] != '0) && (id_q[t] == cpl_id_i);
            cnt_post[t] = cnt_q[t] - CntW'(cpl_hit[t]);
            act_post[t] = cnt_post[t] != '0;
            id_hit[t]   = act_post[t] && (id_q[t] == req_id_i);
            dest_ok[t]  = dest_q[t] == req_dest_i;
        end
        if (|id_hit) begin
            sel_oh = id_hit;
        end else begin
            for (int t = 0; t < N; t++) begin
                if (!act_post[t] && !free_found) begin
                    sel_oh[t]  = 1'b1;
                    free_found = 1'b1;
                end
            end
        end
        admit_o   = (|id_hit) ? |(id_hit & dest_ok) : free_found;
        cpl_hit_o = |cpl_hit;
        for (int t = 0; t < N; t++) begin
            cnt_d[t] = cnt_post[t] + CntW'(start_i && sel_oh[t]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < N; t++) begin
                id_q[t]   <= '0;
                dest_q[t] <= '0;
                cnt_q[t]  <= '0;
            end
        end else begin
            for (int t = 0; t < N; t++) begin
                cnt_q[t] <= cnt_d[t];
                if (start_i && sel_oh[t] && !act_post[t]) begin
                    id_q[t]   <= req_id_i;
                    dest_q[t] <= req_dest_i;
                end
            end
        end
    end

endmodule

// File: rtl/axi_crossbar_addr_adm.sv
// Address decode and admission control for one crossbar slave port; one transaction per cycle.
module axi_crossbar_addr_adm
    import axi_crossbar_addr_adm_pkg::*;
#(
    parameter int unsigned S          = 0,
    parameter int unsigned S_COUNT    = 4,
    parameter int unsigned M_COUNT    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned S_THREADS  = 2,
    parameter int unsigned S_ACCEPT   = 16,
    parameter int unsigned M_REGIONS  = 1,
    parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
    parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH = {M_COUNT{{M_REGIONS{32'd24}}}},
    parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = '1,
    parameter logic [M_COUNT-1:0] M_SECURE = '0,
    parameter logic [M_COUNT*32-1:0] M_ISSUE = {M_COUNT{32'd4}},
    parameter bit WC_OUTPUT = 1'b0,
    localparam int unsigned CL_M_COUNT = clog2_min1(M_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_aid,
    input  logic [ADDR_WIDTH-1:0] s_axi_aaddr,
    input  logic [2:0]            s_axi_aprot,
    input  logic                  s_axi_avalid,
    output logic                  s_axi_aready,
    input  logic [M_COUNT-1:0]    cfg_m_enable,
    output logic [3:0]            m_axi_aregion,
    output logic [CL_M_COUNT-1:0] m_select,
    output logic                  m_axi_avalid,
    input  logic                  m_axi_aready,
    output logic [CL_M_COUNT-1:0] m_wc_select,
    output logic                  m_wc_decerr,
    output logic                  m_wc_valid,
    input  logic                  m_wc_ready,
    output logic                  m_rc_decerr,
    output logic                  m_rc_valid,
    input  logic                  m_rc_ready,
    input  logic [ID_WIDTH-1:0]   s_cpl_id,
    input  logic [CL_M_COUNT-1:0] s_cpl_select,
    input  logic                  s_cpl_decerr,
    input  logic                  s_cpl_valid
);

    localparam int unsigned NR     = M_COUNT * M_REGIONS;
    localparam int unsigned CL_REG = clog2_min1(M_REGIONS);
    localparam int unsigned THR    = min_u(S_THREADS, S_ACCEPT);
    localparam int unsigned CNT_W  = $clog2(S_ACCEPT + 1);
    localparam int unsigned DEST_W = 1 + CL_M_COUNT + CL_REG;

    // Auto-pack assigns each region the next base aligned to its own size.
    function automatic logic [NR*ADDR_WIDTH-1:0] calc_base_addrs();
        logic [NR*ADDR_WIDTH-1:0] res = '0;
        logic [63:0] nxt = '0;
        logic [63:0] size;
        if (M_BASE_ADDR != '0) return M_BASE_ADDR;
        for (int k = 0; k < NR; k++) begin
            if (M_ADDR_WIDTH[k*32 +: 32] != 0) begin
                size = 64'd1 << M_ADDR_WIDTH[k*32 +: 32];
                nxt  = (nxt + size - 64'd1) & ~(size - 64'd1);
                res[k*ADDR_WIDTH +: ADDR_WIDTH] = nxt[ADDR_WIDTH-1:0];
                nxt  = nxt + size;
            end
        end
        return res;
    endfunction

    localparam logic [NR*ADDR_WIDTH-1:0] BASE = calc_base_addrs();

    function automatic bit cfg_ok();
        bit ok = 1'b1;
        logic [63:0] bk, bl;
        int unsigned wk, wl, wm;
        for (int k = 0; k < NR; k++) begin
            wk = M_ADDR_WIDTH[k*32 +: 32];
            bk = 64'(BASE[k*ADDR_WIDTH +: ADDR_WIDTH]);
            if (wk != 0 && (wk < 12 || wk > ADDR_WIDTH)) ok = 1'b0;
            if (wk != 0 && (bk & ((64'd1 << wk) - 64'd1)) != 64'd0) ok = 1'b0;
            for (int l = k + 1; l < NR; l++) begin
                wl = M_ADDR_WIDTH[l*32 +: 32];
                bl = 64'(BASE[l*ADDR_WIDTH +: ADDR_WIDTH]);
                wm = (wk > wl) ? wk : wl;
                if (wk != 0 && wl != 0 && (bk >> wm) == (bl >> wm)) ok = 1'b0;
            end
        end
        for (int i = 0; i < M_COUNT; i++) begin
            if (M_ISSUE[i*32 +: 32] == 0) ok = 1'b0;
        end
        return ok;
    endfunction

    if (!cfg_ok()) begin : g_bad_cfg
        $fatal(1, "axi_crossbar_addr_adm: invalid address map or M_ISSUE");
    end

    logic                  match, thr_admit, cpl_hit, admit, out_free, issue_ok;
    logic [CL_M_COUNT-1:0] dec_m;
    logic [CL_REG-1:0]     dec_r;
    logic [DEST_W-1:0]     dest;
    logic [CNT_W-1:0]      total_q, total_d, total_post;
    logic [M_COUNT-1:0]    issue_dec;
    logic [31:0]           issue_q    [M_COUNT];
    logic [31:0]           issue_d    [M_COUNT];
    logic [31:0]           issue_post [M_COUNT];
    out_valid_t            vld_q, vld_d;
    logic [CL_M_COUNT-1:0] sel_q;
    logic [3:0]            region_q;
    logic                  decerr_q;
    logic                  unused_prot;

    assign unused_prot = ^{s_axi_aprot[2], s_axi_aprot[0]};

    // Ascending scan so the highest matching master/region wins.
    always_comb begin
        match = 1'b0;
        dec_m = '0;
        dec_r = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            for (int j = 0; j < M_REGIONS; j++) begin
                if (M_ADDR_WIDTH[(i*M_REGIONS+j)*32 +: 32] != 0 && M_CONNECT[S+i*S_COUNT] &&
                    !(M_SECURE[i] && s_axi_aprot[1]) && cfg_m_enable[i] &&
                    (s_axi_aaddr >> M_ADDR_WIDTH[(i*M_REGIONS+j)*32 +: 32]) ==
                    (BASE[(i*M_REGIONS+j)*ADDR_WIDTH +: ADDR_WIDTH] >>
                     M_ADDR_WIDTH[(i*M_REGIONS+j)*32 +: 32])) begin
                    match = 1'b1;
                    dec_m = CL_M_COUNT'(i);
                    dec_r = CL_REG'(j);
                end
            end
        end
    end

    assign dest = match ? {1'b0, dec_m, (M_REGIONS > 1) ? dec_r : CL_REG'(0)}
                        : {1'b1, {(DEST_W-1){1'b0}}};

    axi_crossbar_addr_adm_tracker #(
        .N     (THR),
        .IdW   (ID_WIDTH),
        .DestW (DEST_W),
        .CntW  (CNT_W)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_id_i    (s_axi_aid),
        .req_dest_i  (dest),
        .start_i     (s_axi_aready),
        .cpl_id_i    (s_cpl_id),
        .cpl_valid_i (s_cpl_valid),
        .admit_o     (thr_admit),
        .cpl_hit_o   (cpl_hit)
    );

    always_comb begin
        total_post = total_q - CNT_W'(cpl_hit);
        total_d    = total_post + CNT_W'(s_axi_aready);
        issue_dec  = '0;
        issue_post = '{default: '0};
        issue_d    = '{default: '0};
        for (int i = 0; i < M_COUNT; i++) begin
            issue_dec[i]  = cpl_hit && !s_cpl_decerr && (s_cpl_select == CL_M_COUNT'(i));
            issue_post[i] = issue_q[i] - 32'(issue_dec[i]);
            issue_d[i]    = issue_post[i] + 32'(s_axi_aready && match && dec_m == CL_M_COUNT'(i));
        end
        issue_ok = issue_post[dec_m] < M_ISSUE[dec_m*32 +: 32];
        out_free = (!vld_q.a || m_axi_aready) && (!vld_q.wc || m_wc_ready || !WC_OUTPUT) &&
                   (!vld_q.rc || m_rc_ready);
        admit    = (32'(total_post) < S_ACCEPT) && thr_admit && (!match || issue_ok);
        s_axi_aready = s_axi_avalid && out_free && admit;
    end

    always_comb begin
        vld_d = vld_q;
        if (m_axi_aready) vld_d.a = 1'b0;
        if (m_wc_ready)   vld_d.wc = 1'b0;
        if (m_rc_ready)   vld_d.rc = 1'b0;
        if (s_axi_aready) vld_d = '{a: match, wc: WC_OUTPUT, rc: !match};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            sel_q    <= '0;
            region_q <= '0;
            decerr_q <= 1'b0;
            total_q  <= '0;
            for (int i = 0; i < M_COUNT; i++) issue_q[i] <= '0;
        end else begin
            if (cpl_hit) assert (total_q != '0) else $error("total outstanding underflow");
            vld_q   <= vld_d;
            total_q <= total_d;
            for (int i = 0; i < M_COUNT; i++) issue_q[i] <= issue_d[i];
            if (s_axi_aready) begin
                sel_q    <= dec_m;
                region_q <= 4'(dec_r);
                decerr_q <= !match;
            end
        end
    end

    assign m_axi_aregion = region_q;
    assign m_select      = sel_q;
    assign m_axi_avalid  = vld_q.a;
    assign m_wc_select   = sel_q;
    assign m_wc_decerr   = decerr_q;
    assign m_wc_valid    = vld_q.wc;
    assign m_rc_decerr   = decerr_q;
    assign m_rc_valid    = vld_q.rc;

endmodule
